// File: rtl/fir_pkg.sv
// Shared definitions for the serial eight-tap FIR filter.
//   DEF_DATA_W / DEF_TAPS / DEF_COEF_W : default widths and tap count
//   COEFS   : fixed coefficient set, element k is h[k] (h[0] = newest sample)
//   state_e : controller states
package fir_pkg;

  localparam int DEF_DATA_W = 3;
  localparam int DEF_TAPS   = 8;
  localparam int DEF_COEF_W = 4;

  // Symmetric set 1,2,3,4,4,3,2,1. The list is written h[7] first because
  // the leftmost element of a packed concatenation lands on the top index.
  localparam logic [DEF_TAPS-1:0][DEF_COEF_W-1:0] COEFS = {
    4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd3, 4'd2, 4'd1
  };

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MAC  = 1'b1
  } state_e;

endpackage

// File: rtl/fir_delay_line.sv
// Sample delay line for the serial FIR.
//   clk_i      : clock (rising edge)
//   clr_i      : synchronous clear of every tap
//   shift_en_i : shift taps up one place and load sample_i into tap 0
//   sample_i   : newest sample
//   taps_o     : all taps, taps_o[0] is the newest sample
module fir_delay_line #(
  parameter int DATA_W = 3,
  parameter int TAPS   = 8
) (
  input  logic                         clk_i,
  input  logic                         clr_i,
  input  logic                         shift_en_i,
  input  logic [DATA_W-1:0]            sample_i,
  output logic [TAPS-1:0][DATA_W-1:0]  taps_o
);

  logic [TAPS-1:0][DATA_W-1:0] taps_q;

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      taps_q <= '0;
    end else if (shift_en_i) begin
      taps_q <= {taps_q[TAPS-2:0], sample_i};
    end
  end

  assign taps_o = taps_q;

endmodule

// File: rtl/fir_serial_filter.sv
// Eight-tap FIR with a single multiplier, one tap per clock.
//   CLOCK_50     : clock (rising edge)
//   reset        : synchronous active-high reset
//   sample_in    : newest sample, taken when sample_valid is high in IDLE
//   sample_valid : sample_in is offered this cycle
//   busy         : MAC in progress; samples offered now are dropped
//   result       : last completed filter output, held until the next one
//   result_valid : one-cycle pulse in the first cycle a new result is visible
//   overrun      : sticky flag, set when a sample is dropped
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | waiting for a sample; an offered sample is accepted at once
// ST_MAC  | accumulating h[idx]*x[idx], idx = 0..TAPS-1, one tap per clock
module fir_serial_filter
  import fir_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int TAPS   = DEF_TAPS,
  parameter int COEF_W = DEF_COEF_W,
  parameter int ACC_W  = DATA_W + COEF_W + $clog2(TAPS)
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic              busy,
  output logic [ACC_W-1:0]  result,
  output logic              result_valid,
  output logic              overrun
);

  localparam int IDX_W  = $clog2(TAPS);
  localparam int PROD_W = DATA_W + COEF_W;

  state_e                      state_q;
  logic [IDX_W-1:0]            idx_q;
  logic [ACC_W-1:0]            acc_q;
  logic [ACC_W-1:0]            result_q;
  logic                        result_valid_q;
  logic                        busy_q;
  logic                        overrun_q;

  logic [TAPS-1:0][DATA_W-1:0] taps;
  logic [COEF_W-1:0]           coef;
  logic [DATA_W-1:0]           tap;
  logic [PROD_W-1:0]           prod;
  logic [ACC_W-1:0]            acc_d;
  logic                        last_tap;
  logic                        accept;

  // The delay line only moves on acceptance, so x[] is frozen for the MAC.
  assign accept = (state_q == ST_IDLE) && sample_valid;

  fir_delay_line #(
    .DATA_W (DATA_W),
    .TAPS   (TAPS)
  ) u_delay_line (
    .clk_i      (CLOCK_50),
    .clr_i      (reset),
    .shift_en_i (accept),
    .sample_i   (sample_in),
    .taps_o     (taps)
  );

  assign coef     = COEFS[idx_q];
  assign tap      = taps[idx_q];
  assign prod     = PROD_W'(coef) * PROD_W'(tap);
  assign acc_d    = acc_q + ACC_W'(prod);
  assign last_tap = (idx_q == IDX_W'(TAPS - 1));

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      idx_q          <= '0;
      acc_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (sample_valid) begin
            acc_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_MAC;
          end
        end
        ST_MAC: begin
          acc_q <= acc_d;
          idx_q <= idx_q + 1'b1;
          if (sample_valid) begin
            overrun_q <= 1'b1;
          end
          // The final product goes straight into result so the answer is
          // visible the cycle after the last tap, not one cycle later.
          if (last_tap) begin
            result_q       <= acc_d;
            result_valid_q <= 1'b1;
            busy_q         <= 1'b0;
            state_q        <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign overrun      = overrun_q;

endmodule

// File: doc/fir_serial_filter.md
# fir_serial_filter

Eight-tap FIR filter that consumes the 3-bit unsigned sample stream from the signal generator and produces a filtered result. It uses one multiplier and a sequential multiply-accumulate, spending one clock per tap. It sits directly downstream of the signal generator. A `sample_valid` strobe gates which generator outputs enter the filter.

## Interface
- `DATA_W`, 3: input sample width, unsigned.
- `TAPS`, 8: number of taps. Must be a power of two and ≥ 2.
- `COEF_W`, 4: coefficient width, unsigned.
- `ACC_W`, `DATA_W+COEF_W+$clog2(TAPS)` (= 10): accumulator and result width.

Ports:
- `CLOCK_50` in 1: the only clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high.
- `sample_in` in `DATA_W`: newest sample (generator `signal`).
- `sample_valid` in 1: `sample_in` is offered this cycle.
- `busy` out 1: a MAC is in progress. Samples offered while `busy` is high are dropped.
- `result` out `ACC_W`: last completed filter output. Held until the next completion.
- `result_valid` out 1: one-cycle pulse in the first cycle a new `result` is visible.
- `overrun` out 1: sticky. Set when a sample is dropped; cleared only by reset.

## Operation
- Fixed coefficients h[0..7] = 1,2,3,4,4,3,2,1 (symmetric, sum 20). h[0] applies to the newest sample.
- Delay line x[0..TAPS-1], where x[0] is the newest sample.
- Output definition: y = Σ h[k]·x[k], unsigned, no truncation.
  - Maximum is 7·20 = 140, so no overflow in `ACC_W`.
- States: IDLE, MAC.
- **IDLE**, `sample_valid`=1:
  - shift the delay line (x[k] ← x[k-1], x[0] ← `sample_in`);
  - acc ← 0, idx ← 0;
  - go to MAC.
- **IDLE**, `sample_valid`=0: hold everything.
- **MAC**, each cycle:
  - acc ← acc + h[idx]·x[idx];
  - idx ← idx+1.
- **MAC**, when idx = TAPS-1:
  - `result` ← acc + h[idx]·x[idx];
  - `result_valid` ← 1;
  - go to IDLE.
- **MAC**, `sample_valid`=1: the sample is dropped, `overrun` ← 1, and the delay line is untouched.
- `result_valid` is 0 in every cycle other than the completion pulse.
- The delay line shifts only when a sample is accepted, never during MAC.
- Reset values:
  - state IDLE;
  - x[*]=0, acc=0, idx=0;
  - `result`=0, `result_valid`=0, `busy`=0, `overrun`=0.
- Reset during MAC aborts the computation. No `result_valid` pulse is produced, and the delay line is cleared.

## Timing
- `busy` is registered and equals (state==MAC).
- Acceptance occurs at edge E0, which is the edge where `sample_valid`=1 and state=IDLE.
- MAC occupies edges E1..E_TAPS.
- `result`/`result_valid` update at edge E_TAPS.
- Latency: `result_valid` is high in the cycle following E_TAPS, i.e. TAPS cycles after acceptance.
- In that same cycle the state is IDLE, so a new sample can be accepted on that cycle.
- Maximum throughput: 1 sample per TAPS+1 = 9 clocks.
- `sample_valid` in the same cycle as the completion pulse is accepted, because state is already IDLE.

## Structure
- Package `fir_pkg` holds:
  - the `TAPS`, `DATA_W`, `COEF_W` defaults;
  - the coefficient constant array;
  - the state enum (IDLE, MAC).
- Sub-module `fir_delay_line` (parameters `DATA_W`, `TAPS`):
  - inputs: shift enable, clear on reset;
  - outputs: all taps, from which the parent selects x[idx].
- Top-level `fir_serial_filter` contains the FSM, the tap index counter, the single multiplier and the accumulator.

## Test plan
- **Impulse:** feed 1 then zeros, spaced 9 clocks apart. Successive `result` values must be 1,2,3,4,4,3,2,1,0, each with exactly one `result_valid` pulse arriving 8 clocks after acceptance.
- **Step:** feed constant 7 for 8+ samples. Results must be 7,21,42,70,98,119,133,140, then 140 steady.
- **Ramp from generator:** feed 0..7 with a divide-by-9 strobe. The 8th result must be 70; the 9th (sample 0 wraps in) must be 1·0+2·7+3·6+4·5+4·4+3·3+2·2+1·1 = 82.
- **Overrun:**
  - Stimulus: pulse `sample_valid` with value 5 three clocks after an accepted 1 (delay line zero).
  - Expect: `overrun`=1 and it stays 1.
  - Expect: `result`=1 (5 never enters the delay line).
  - Expect: the next accepted sample 0 gives 2.
- **Back-to-back:** assert `sample_valid` in the `result_valid` cycle. The sample must be accepted, with `busy` high on the next cycle and no overrun.
- **Reset mid-MAC:** accept 7, then assert reset 4 clocks later. Expect:
  - no `result_valid` pulse;
  - all outputs 0 the cycle after reset;
  - next accepted 7 gives `result`=7.
